basic_gates: RTL and testbench



---
 rtl/basic_gates_pkg.sv | 17 +
 rtl/basic_gates_comb.sv | 23 ++
 rtl/basic_gates.sv | 61 ++++++
 tb/tb_basic_gates.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/basic_gates_pkg.sv
// Shared definitions for the basic_gates bank: output count and the fixed gate order
// used to index the result vector.
package basic_gates_pkg;

    localparam int GATE_N = 7;

    typedef enum logic [2:0] {
        G_AND  = 3'd0,
        G_OR   = 3'd1,
        G_NOT  = 3'd2,
        G_NAND = 3'd3,
        G_NOR  = 3'd4,
        G_XOR  = 3'd5,
        G_XNOR = 3'd6
    } gate_e;

endpackage

// File: rtl/basic_gates_comb.sv
// Purely combinational gate bank: seven bitwise functions of i_a and i_b, indexed by gate_e.
module basic_gates_comb
    import basic_gates_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    output logic [GATE_N-1:0][WIDTH-1:0] o_y
);

    always_comb begin
        o_y         = '0;
        o_y[G_AND]  = i_a & i_b;
        o_y[G_OR]   = i_a | i_b;
        o_y[G_NOT]  = ~i_a;
        o_y[G_NAND] = ~(i_a & i_b);
        o_y[G_NOR]  = ~(i_a | i_b);
        o_y[G_XOR]  = i_a ^ i_b;
        o_y[G_XNOR] = ~(i_a ^ i_b);
    end

endmodule

// File: rtl/basic_gates.sv
// Bitwise two-input gate bank with an optional output register stage selected by REG_OUT.
module basic_gates
    import basic_gates_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6
);

    logic [GATE_N-1:0][WIDTH-1:0] w_gate;
    logic [GATE_N-1:0][WIDTH-1:0] w_out;

    basic_gates_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_a (a),
        .i_b (b),
        .o_y (w_gate)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [GATE_N-1:0][WIDTH-1:0] r_y;

            // Reset clears every output to zero, including the inverting gates.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= '0;
                end else begin
                    r_y <= w_gate;
                end
            end

            assign w_out = r_y;
        end else begin : g_comb
            logic w_unused_ctl;
            assign w_unused_ctl = clk & rst_n;
            assign w_out        = w_gate;
        end
    endgenerate

    assign y0 = w_out[G_AND];
    assign y1 = w_out[G_OR];
    assign y2 = w_out[G_NOT];
    assign y3 = w_out[G_NAND];
    assign y4 = w_out[G_NOR];
    assign y5 = w_out[G_XOR];
    assign y6 = w_out[G_XNOR];

endmodule

// File: tb/tb_basic_gates.sv
// Directed and randomised bench for basic_gates across WIDTH=1/8/16 registered and WIDTH=1 combinational.
module tb_basic_gates;

    logic clk;
    logic rst_n;
    logic rst_c;

    logic       a1, b1;
    logic       y1w [7];
    logic [7:0] a8, b8;
    logic [7:0] y8w [7];
    logic       ac, bc;
    logic       ycw [7];
    logic [15:0] a16, b16;
    logic [15:0] y16w [7];

    int checks;
    int errors;

    // Expected y0..y6 packed MSB-first (y0 in bit 6) for (a,b) = 00,01,10,11.
    logic [6:0] tt_exp [4];

    basic_gates #(.WIDTH(1), .REG_OUT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .y0(y1w[0]), .y1(y1w[1]), .y2(y1w[2]), .y3(y1w[3]),
        .y4(y1w[4]), .y5(y1w[5]), .y6(y1w[6])
    );

    basic_gates #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
        .y0(y8w[0]), .y1(y8w[1]), .y2(y8w[2]), .y3(y8w[3]),
        .y4(y8w[4]), .y5(y8w[5]), .y6(y8w[6])
    );

    basic_gates #(.WIDTH(1), .REG_OUT(0)) u_c (
        .clk(clk), .rst_n(rst_c), .a(ac), .b(bc),
        .y0(ycw[0]), .y1(ycw[1]), .y2(ycw[2]), .y3(ycw[3]),
        .y4(ycw[4]), .y5(ycw[5]), .y6(ycw[6])
    );

    basic_gates #(.WIDTH(16), .REG_OUT(1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16),
        .y0(y16w[0]), .y1(y16w[1]), .y2(y16w[2]), .y3(y16w[3]),
        .y4(y16w[4]), .y5(y16w[5]), .y6(y16w[6])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref16(input int g, input logic [15:0] x, input logic [15:0] z);
        case (g)
            0:       ref16 = x & z;
            1:       ref16 = x | z;
            2:       ref16 = ~x;
            3:       ref16 = ~(x & z);
            4:       ref16 = ~(x | z);
            5:       ref16 = x ^ z;
            default: ref16 = ~(x ^ z);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (y1w[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold_y%0d cyc%0d got %b want 0", g, c, y1w[g]);
                end
                checks++;
                if (y8w[g] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_hold_w8_y%0d cyc%0d got %h want 00", g, c, y8w[g]);
                end
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 7; g++) begin
            checks++;
            if (y1w[g] !== tt_exp[3][6-g]) begin
                errors++;
                $display("FAIL reset_release_y%0d got %b want %b", g, y1w[g], tt_exp[3][6-g]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 7; g++) begin
            checks++;
            if (y1w[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async_y%0d got %b want 0", g, y1w[g]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        for (int v = 0; v < 4; v++) begin
            a1 = v[1]; b1 = v[0];
            @(posedge clk); #1;
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (y1w[g] !== tt_exp[v][6-g]) begin
                    errors++;
                    $display("FAIL truth_ab%0d_y%0d got %b want %b", v, g, y1w[g], tt_exp[v][6-g]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int seq [6];
        seq = '{0, 3, 1, 2, 3, 0};
        a1 = seq[0][1]; b1 = seq[0][0];
        @(posedge clk); #1;
        for (int k = 1; k < 6; k++) begin
            a1 = seq[k][1]; b1 = seq[k][0];
            #1;
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (y1w[g] !== tt_exp[seq[k-1]][6-g]) begin
                    errors++;
                    $display("FAIL latency_hold_k%0d_y%0d got %b want %b", k, g, y1w[g], tt_exp[seq[k-1]][6-g]);
                end
            end
            @(posedge clk); #1;
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (y1w[g] !== tt_exp[seq[k]][6-g]) begin
                    errors++;
                    $display("FAIL latency_load_k%0d_y%0d got %b want %b", k, g, y1w[g], tt_exp[seq[k]][6-g]);
                end
            end
        end
    endtask

    task automatic test_bitwise8();
        logic [7:0] exp_a [7];
        logic [7:0] exp_b [7];
        exp_a = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};
        exp_b = '{8'h0A, 8'hAF, 8'h55, 8'hF5, 8'h50, 8'hA5, 8'h5A};
        a8 = 8'hF0; b8 = 8'hCC;
        @(posedge clk); #1;
        for (int g = 0; g < 7; g++) begin
            checks++;
            if (y8w[g] !== exp_a[g]) begin
                errors++;
                $display("FAIL bitwise8_F0CC_y%0d got %h want %h", g, y8w[g], exp_a[g]);
            end
        end
        a8 = 8'hAA; b8 = 8'h0F;
        @(posedge clk); #1;
        for (int g = 0; g < 7; g++) begin
            checks++;
            if (y8w[g] !== exp_b[g]) begin
                errors++;
                $display("FAIL bitwise8_AA0F_y%0d got %h want %h", g, y8w[g], exp_b[g]);
            end
        end
    endtask

    task automatic test_comb();
        rst_c = 1'b0;
        for (int v = 0; v < 4; v++) begin
            ac = v[1]; bc = v[0];
            #1;
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (ycw[g] !== tt_exp[v][6-g]) begin
                    errors++;
                    $display("FAIL comb_ab%0d_y%0d got %b want %b", v, g, ycw[g], tt_exp[v][6-g]);
                end
            end
            #9;
        end
        rst_c = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] na, nb, want;
        bit do_rst;
        for (int i = 0; i < 1000; i++) begin
            na = 16'($urandom);
            nb = 16'($urandom);
            a16 = na; b16 = nb;
            do_rst = ($urandom_range(0, 39) == 0);
            if (do_rst) begin
                rst_n = 1'b0;
                #2;
                for (int g = 0; g < 7; g++) begin
                    checks++;
                    if (y16w[g] !== 16'h0000) begin
                        errors++;
                        $display("FAIL rand_async_rst i%0d y%0d got %h want 0000", i, g, y16w[g]);
                    end
                end
            end
            @(posedge clk); #1;
            for (int g = 0; g < 7; g++) begin
                want = do_rst ? 16'h0000 : ref16(g, na, nb);
                checks++;
                if (y16w[g] !== want) begin
                    errors++;
                    $display("FAIL rand_i%0d_y%0d got %h want %h", i, g, y16w[g], want);
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tt_exp = '{7'b0011101, 7'b0111010, 7'b0101010, 7'b1100001};
        rst_n = 1'b0; rst_c = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
        ac = 1'b0; bc = 1'b0; a16 = '0; b16 = '0;
        #1;
        test_reset();
        test_truth_table();
        test_latency();
        test_bitwise8();
        test_comb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
